// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging a single MIPS-style request to an Avalon-MM master port.
// Handles lane steering, store replication, load extension, alignment errors and bus timeout.
module mips_bus_lsu #(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [1:0]         size_r, size_nxt;
    logic               sgn_r, sgn_nxt;
    logic [1:0]         off_r, off_nxt;
    logic               write_r, write_r_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        address_nxt, writedata_nxt, resp_rdata_nxt;
    logic               read_nxt, write_nxt, resp_valid_nxt;
    logic [3:0]         byteenable_nxt;
    logic [1:0]         resp_error_nxt;

    logic               misaligned;
    logic [1:0]         req_lane, ld_lane;
    logic [3:0]         be_req;
    logic [31:0]        wdata_rep, load_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Only IDLE accepts; held low through reset.
    assign req_ready = (state == IDLE) && !reset;

    // Request decode: alignment, lane enables and replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be_req     = 4'b1111;
        wdata_rep  = req_wdata;
        req_lane   = BIG_ENDIAN ? 2'(2'd3 - req_addr[1:0]) : req_addr[1:0];
        case (req_size)
            2'b00: begin
                be_req    = 4'(4'b0001 << req_lane);
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be_req     = (BIG_ENDIAN ? !req_addr[1] : req_addr[1]) ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{req_wdata[15:0]}};
            end
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Load lane select and extension from the registered request.
    always_comb begin
        ld_lane   = BIG_ENDIAN ? 2'(2'd3 - off_r) : off_r;
        ld_byte   = readdata[{ld_lane, 3'b000} +: 8];
        ld_half   = (BIG_ENDIAN ? !off_r[1] : off_r[1]) ? readdata[31:16] : readdata[15:0];
        case (size_r)
            2'b00:   load_data = {{24{sgn_r & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{sgn_r & ld_half[15]}}, ld_half};
            default: load_data = readdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        size_nxt       = size_r;
        sgn_nxt        = sgn_r;
        off_nxt        = off_r;
        write_r_nxt    = write_r;
        cnt_nxt        = cnt;
        address_nxt    = address;
        read_nxt       = read;
        write_nxt      = write;
        writedata_nxt  = writedata;
        byteenable_nxt = byteenable;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = resp_rdata;
        resp_error_nxt = resp_error;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    size_nxt    = req_size;
                    sgn_nxt     = req_signed;
                    off_nxt     = req_addr[1:0];
                    write_r_nxt = req_write;
                    if (misaligned) begin
                        state_nxt      = RESP;
                        resp_error_nxt = 2'b01;
                        resp_rdata_nxt = '0;
                    end else begin
                        state_nxt      = BUS;
                        cnt_nxt        = '0;
                        address_nxt    = {req_addr[31:2], 2'b00};
                        read_nxt       = !req_write;
                        write_nxt      = req_write;
                        writedata_nxt  = wdata_rep;
                        byteenable_nxt = be_req;
                    end
                end
            end
            BUS: begin
                // A completing handshake wins over a timeout on the same cycle.
                if (!waitrequest) begin
                    state_nxt      = RESP;
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    resp_error_nxt = 2'b00;
                    resp_rdata_nxt = write_r ? 32'h0 : load_data;
                end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT))) begin
                    state_nxt      = RESP;
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    resp_error_nxt = 2'b10;
                    resp_rdata_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                resp_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            size_r     <= '0;
            sgn_r      <= 1'b0;
            off_r      <= '0;
            write_r    <= 1'b0;
            cnt        <= '0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= '0;
        end else begin
            state      <= state_nxt;
            size_r     <= size_nxt;
            sgn_r      <= sgn_nxt;
            off_r      <= off_nxt;
            write_r    <= write_r_nxt;
            cnt        <= cnt_nxt;
            address    <= address_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            writedata  <= writedata_nxt;
            byteenable <= byteenable_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_error <= resp_error_nxt;
        end
    end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed bench for mips_bus_lsu: three instances (big-endian, little-endian, TIMEOUT=4)
// share stimulus; per-instance scoreboards check response data, error and arrival cycle.
module tb_mips_bus_lsu;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed, waitrequest;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, readdata;

    logic        req_ready[N];
    logic        resp_valid[N];
    logic [31:0] resp_rdata[N];
    logic [1:0]  resp_error[N];
    logic [31:0] address[N];
    logic        read[N];
    logic        write[N];
    logic [31:0] writedata[N];
    logic [3:0]  byteenable[N];

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          due;
    } exp_t;

    exp_t sb[N][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_bus_lsu #(.BIG_ENDIAN(1'b1), .TIMEOUT(255)) dut_be (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .address(address[0]),
        .read(read[0]), .write(write[0]), .writedata(writedata[0]),
        .byteenable(byteenable[0]), .waitrequest(waitrequest), .readdata(readdata));

    mips_bus_lsu #(.BIG_ENDIAN(1'b0), .TIMEOUT(255)) dut_le (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .address(address[1]),
        .read(read[1]), .write(write[1]), .writedata(writedata[1]),
        .byteenable(byteenable[1]), .waitrequest(waitrequest), .readdata(readdata));

    mips_bus_lsu #(.BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[2]),
        .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]), .address(address[2]),
        .read(read[2]), .write(write[2]), .writedata(writedata[2]),
        .byteenable(byteenable[2]), .waitrequest(waitrequest), .readdata(readdata));

    task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Expected response arrives lat cycles after the accepting edge (the next posedge).
    task automatic push(int d, logic [31:0] rd, logic [1:0] er, int lat);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.due   = cyc + 1 + lat;
        sb[d].push_back(e);
    endtask

    task automatic push_all(logic [31:0] rd, logic [1:0] er, int lat);
        for (int d = 0; d < N; d++) push(d, rd, er, lat);
    endtask

    task automatic drive(logic wr, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic step();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready[0] && req_ready[1] && req_ready[2]) && n < 50);
        check("idle_reached", 32'(req_ready[0] && req_ready[1] && req_ready[2]), 32'd1);
    endtask

    task automatic score(int d);
        exp_t e;
        check($sformatf("dut%0d_resp_expected", d), 32'(sb[d].size() != 0), 32'd1);
        if (sb[d].size() != 0) begin
            e = sb[d].pop_front();
            check($sformatf("dut%0d_rdata", d), resp_rdata[d], e.rdata);
            check($sformatf("dut%0d_error", d), 32'(resp_error[d]), 32'(e.err));
            check($sformatf("dut%0d_latency_cycle", d), 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < N; d++) begin
                if (resp_valid[d]) score(d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd0);
            check("rst_read", 32'(read[d]), 32'd0);
            check("rst_write", 32'(write[d]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
        end
        check("rst_address", address[0], 32'h0);
        check("rst_byteenable", 32'(byteenable[0]), 32'h0);
        check("rst_writedata", writedata[0], 32'h0);
        check("rst_resp_rdata", resp_rdata[0], 32'h0);
        check("rst_resp_error", 32'(resp_error[0]), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) check("post_rst_ready", 32'(req_ready[d]), 32'd1);

        // Word load, no wait states.
        readdata = 32'hDEADBEEF;
        drive(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
        push_all(32'hDEADBEEF, 2'b00, 2);
        step();
        check("wl_address", address[0], 32'h0000_1000);
        check("wl_byteenable", 32'(byteenable[0]), 32'hF);
        check("wl_read", 32'(read[0]), 32'd1);
        check("wl_write", 32'(write[0]), 32'd0);
        check("wl_ready_busy", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("wl_read_drop", 32'(read[0]), 32'd0);
        wait_idle();

        // Signed then unsigned byte load at offset 3.
        readdata = 32'h112233F0;
        drive(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
        push(0, 32'hFFFFFFF0, 2'b00, 2);
        push(1, 32'h00000011, 2'b00, 2);
        push(2, 32'hFFFFFFF0, 2'b00, 2);
        step();
        check("bl_be_big", 32'(byteenable[0]), 32'h1);
        check("bl_be_little", 32'(byteenable[1]), 32'h8);
        wait_idle();
        drive(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
        push(0, 32'h000000F0, 2'b00, 2);
        push(1, 32'h00000011, 2'b00, 2);
        push(2, 32'h000000F0, 2'b00, 2);
        step();
        wait_idle();

        // Signed half load at offset 2.
        readdata = 32'h80017FFF;
        drive(1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0);
        push(0, 32'h00007FFF, 2'b00, 2);
        push(1, 32'hFFFF8001, 2'b00, 2);
        push(2, 32'h00007FFF, 2'b00, 2);
        step();
        check("hl_be_big", 32'(byteenable[0]), 32'h3);
        check("hl_be_little", 32'(byteenable[1]), 32'hC);
        wait_idle();

        // Half store with three wait states; a new req_valid during BUS is ignored.
        waitrequest = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000ABCD);
        push_all(32'h0, 2'b00, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) req_addr = 32'h0000_5000;
            if (i == 2) req_valid = 1'b0;
            check("hs_address", address[0], 32'h0000_2000);
            check("hs_be_big", 32'(byteenable[0]), 32'h3);
            check("hs_be_little", 32'(byteenable[1]), 32'hC);
            check("hs_writedata", writedata[0], 32'hABCDABCD);
            check("hs_write", 32'(write[0]), 32'd1);
            check("hs_read", 32'(read[0]), 32'd0);
            if (i == 3) waitrequest = 1'b0;
        end
        @(negedge clk);
        check("hs_write_drop", 32'(write[0]), 32'd0);
        wait_idle();

        // Misaligned word and illegal size: no bus cycle.
        drive(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0);
        push_all(32'h0, 2'b01, 1);
        step();
        check("mis_read", 32'(read[0]), 32'd0);
        check("mis_write", 32'(write[0]), 32'd0);
        wait_idle();
        drive(1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0);
        push_all(32'h0, 2'b01, 1);
        step();
        check("ill_read", 32'(read[0]), 32'd0);
        wait_idle();

        // Waitrequest held: TIMEOUT=4 instance aborts, the others complete later.
        readdata = 32'hCAFEF00D;
        waitrequest = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        push(0, 32'hCAFEF00D, 2'b00, 11);
        push(1, 32'hCAFEF00D, 2'b00, 11);
        push(2, 32'h0, 2'b10, 6);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) req_valid = 1'b0;
            hi += int'(read[2]);
            if (i == 9) waitrequest = 1'b0;
        end
        check("to_read_cycles", 32'(hi), 32'd5);
        wait_idle();

        // Waitrequest falls exactly when the counter reaches TIMEOUT: success.
        readdata = 32'h0BADF00D;
        waitrequest = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0);
        push_all(32'h0BADF00D, 2'b00, 6);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) req_valid = 1'b0;
            hi += int'(read[2]);
            if (i == 4) waitrequest = 1'b0;
        end
        check("edge_read_cycles", 32'(hi), 32'd5);
        wait_idle();

        // Reset during a stalled read aborts without a response.
        waitrequest = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        step();
        check("ab_read_before", 32'(read[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("ab_read_after", 32'(read[0]), 32'd0);
        check("ab_read_after_to", 32'(read[2]), 32'd0);
        check("ab_ready_in_reset", 32'(req_ready[0]), 32'd0);
        reset = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("ab_no_resp", 32'(resp_valid[d]), 32'd0);
            check("ab_ready", 32'(req_ready[d]), 32'd1);
        end

        // Normal word store afterwards.
        drive(1'b1, 2'b10, 1'b0, 32'h0000_4004, 32'h12345678);
        push_all(32'h0, 2'b00, 2);
        step();
        check("ws_address", address[0], 32'h0000_4004);
        check("ws_writedata", writedata[0], 32'h12345678);
        check("ws_be", 32'(byteenable[0]), 32'hF);
        check("ws_write", 32'(write[0]), 32'd1);
        wait_idle();

        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) check("sb_drained", 32'(sb[d].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
